// File: rtl/f1.sv
// f1: three-input Boolean function cell, f = TT[{a,b,c}].
// The same index also drives a one-hot minterm decode. With REG_OUT=1 both
// outputs pass through one register stage clocked by clk with a synchronous,
// active-high reset that clears them to zero.
module f1 #(
  parameter logic [7:0] TT      = 8'hE8,
  parameter bit         REG_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       f,
  output logic [7:0] minterm
);

  // a is the most significant bit of the truth-table index.
  logic [2:0] idx;
  assign idx = {a, b, c};

  // Next-state values: the table lookup and the one-hot decode.
  logic       f_d;
  logic [7:0] minterm_d;

  // Combinational lookup of the function value and the minterm decode.
  always_comb begin
    f_d       = 1'b0;
    minterm_d = 8'h00;
    f_d       = TT[idx];
    minterm_d = 8'b0000_0001 << idx;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic       f_q;
      logic [7:0] minterm_q;

      // Output register stage; reset has priority over new data.
      always_ff @(posedge clk) begin
        if (rst) begin
          f_q       <= 1'b0;
          minterm_q <= 8'h00;
        end else begin
          f_q       <= f_d;
          minterm_q <= minterm_d;
        end
      end

      assign f       = f_q;
      assign minterm = minterm_q;
    end else begin : g_comb
      // clk and rst are deliberately ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};

      assign f       = f_d;
      assign minterm = minterm_d;
    end
  endgenerate

endmodule

// File: tb/tb_f1.sv
// Bench for f1: two combinational builds (majority and XOR3 tables) and one
// registered majority build. Drivers push expected {f, minterm} values into
// queues; monitor processes pop and compare them against the DUT outputs.
module tb_f1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       ca = 1'b0, cb = 1'b0, cc = 1'b0;
  logic       tie_clk = 1'b0, tie_rst = 1'b0;
  logic       f_maj, f_xor;
  logic [7:0] mt_maj, mt_xor;

  logic       rrst = 1'b1, ra = 1'b0, rb = 1'b0, rc = 1'b0;
  logic       f_reg;
  logic [7:0] mt_reg;

  f1 #(.TT(8'hE8), .REG_OUT(1'b0)) u_maj (
    .clk(tie_clk), .rst(tie_rst), .a(ca), .b(cb), .c(cc),
    .f(f_maj), .minterm(mt_maj)
  );

  f1 #(.TT(8'h96), .REG_OUT(1'b0)) u_xor (
    .clk(tie_clk), .rst(tie_rst), .a(ca), .b(cb), .c(cc),
    .f(f_xor), .minterm(mt_xor)
  );

  f1 #(.TT(8'hE8), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rrst), .a(ra), .b(rb), .c(rc),
    .f(f_reg), .minterm(mt_reg)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_maj_q[$];
  logic [8:0] exp_xor_q[$];
  logic [8:0] exp_reg_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model from the functional description: majority means two or
  // more ones, XOR3 means an odd number of ones, minterm is 2**index.
  function automatic logic [8:0] model(input int kind, input bit r,
                                       input bit a, input bit b, input bit c);
    int n;
    int index;
    logic fv;
    logic [7:0] mv;
    n     = int'(a) + int'(b) + int'(c);
    index = int'(a) * 4 + int'(b) * 2 + int'(c);
    fv    = (kind == 0) ? (n >= 2) : (n % 2 == 1);
    mv    = 8'(2 ** index);
    if (r) begin
      fv = 1'b0;
      mv = 8'h00;
    end
    return {fv, mv};
  endfunction

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got f=%b minterm=%h, expected f=%b minterm=%h",
               name, act[8], act[7:0], exp[8], exp[7:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Combinational step: apply inputs and queue the expected outputs.
  task automatic comb_step(input bit a, input bit b, input bit c);
    ca = a; cb = b; cc = c;
    exp_maj_q.push_back(model(0, 1'b0, a, b, c));
    exp_xor_q.push_back(model(1, 1'b0, a, b, c));
    #2;
  endtask

  // Registered step: apply inputs on the falling edge; the expected value
  // is what the outputs must show after the next rising edge.
  task automatic reg_cycle(input bit r, input bit a, input bit b, input bit c);
    @(negedge clk);
    rrst = r; ra = a; rb = b; rc = c;
    exp_reg_q.push_back(model(0, r, a, b, c));
  endtask

  // ---------------- monitors ----------------
  // Combinational monitor: compare 1 time unit after each input change.
  initial begin
    logic [8:0] e;
    forever begin
      wait (exp_maj_q.size() > 0);
      #1;
      e = exp_maj_q.pop_front();
      check("comb_maj", {f_maj, mt_maj}, e);
      if (exp_xor_q.size() > 0) begin
        e = exp_xor_q.pop_front();
        check("comb_xor", {f_xor, mt_xor}, e);
      end
    end
  end

  // Registered monitor: compare just after each rising edge, then again
  // after the inputs have moved to confirm the outputs held between edges.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      if (exp_reg_q.size() > 0) begin
        e = exp_reg_q.pop_front();
        #1;
        check("reg_edge", {f_reg, mt_reg}, e);
        #5;
        check("reg_hold", {f_reg, mt_reg}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    // Combinational sweeps (majority and XOR3 checked side by side).
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      comb_step(v[2], v[1], v[0]);
    end
    // Random combinational patterns.
    for (int i = 0; i < 20; i++)
      comb_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));

    // Registered: reset held for two edges with abc=111, then release.
    reg_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    reg_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    reg_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    // Consecutive inputs 011 then 100.
    reg_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    reg_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    // Mid-sweep reset with abc=101, then the same input with reset released.
    reg_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    reg_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    reg_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    reg_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    // Randomized registered traffic with occasional resets.
    for (int i = 0; i < 40; i++)
      reg_cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Drain the queues with a bounded wait.
    waited = 0;
    while ((exp_reg_q.size() > 0 || exp_maj_q.size() > 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (exp_reg_q.size() > 0 || exp_maj_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d registered and %0d combinational entries left, expected 0",
               exp_reg_q.size(), exp_maj_q.size());
    end
    repeat (2) @(negedge clk);
    #2;

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
